cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//   Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the microcpu core.
//   Owns the PC and instruction register (IR) and drives a single shared memory port with a req/ready handshake.
//   Consumes the decoded controls (load_pc, mem_rd/wr, reg_write_enable) from the combinational decoder fed by IR.
//   Issues one-cycle register-file and status-register write strobes.
// PARAMETERS
//   ADDR_W          26   PC / memory address width (matches jump target field)
//   RESET_PC        0    PC value loaded on reset
//   TIMEOUT_CYCLES  255  max mem_ready wait before fault (only with SEQ_TIMEOUT_EN)
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   run          in   1       1 = sequence instructions; sampled only in FETCH before issuing request
//   mem_ready    in   1       memory completes current request this cycle
//   mem_rdata    in   32      read data (instruction in FETCH, load data in MEM)
//   cu_load_pc   in   1       decoder: take branch
//   cu_pc_val    in   ADDR_W  decoder: branch target
//   cu_mem_rd    in   1       decoder: load
//   cu_mem_wr    in   1       decoder: store
//   cu_reg_we    in   1       decoder: instruction writes a register
//   cu_alu_act   in   1       decoder: alu_op != NOP (ALU/CMP updates flags)
//   data_addr    in   32      register-file src1 value used as load/store address
//   pc           out  ADDR_W  program counter
//   ir           out  32      instruction register (decoder input)
//   mem_req      out  1       memory request valid
//   mem_we       out  1       1 = write (store), 0 = read
//   mem_addr     out  ADDR_W  request address
//   reg_we       out  1       one-cycle register-file write strobe
//   status_we    out  1       one-cycle status-register update strobe
//   state_o      out  3       current FSM state (debug)
//   fault        out  1       sticky bus fault (SEQ_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
//   Reset (async, immediate): state=FETCH, pc=RESET_PC, ir=0, mem_req=mem_we=reg_we=status_we=fault=0, mem_addr=0.
//   A pending request is dropped on reset.
//   FETCH:
//     - run=0: idle in FETCH, mem_req=0.
//     - run=1: mem_req=1, mem_we=0, mem_addr=pc.
//     - On mem_ready: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W), go DECODE.
//   DECODE: 1 cycle, decoder settles on new ir; go EXEC.
//   EXEC: status_we=cu_alu_act for this cycle. Next state, in priority order:
//     - cu_load_pc: pc<=cu_pc_val; go FETCH.
//     - cu_mem_rd | cu_mem_wr: latch mem_addr=data_addr[ADDR_W-1:0] and mem_we=cu_mem_wr & ~cu_mem_rd; go MEM.
//       If cu_mem_rd and cu_mem_wr are both set, the read wins.
//     - cu_reg_we: go WB.
//     - otherwise: go FETCH.
//   MEM: mem_req=1; addr/we held stable until mem_ready. On ready: read -> WB; write -> FETCH.
//   WB: reg_we=1 for exactly one cycle (load data = mem_rdata captured at MEM ready); go FETCH.
//   Handshake:
//     - mem_req, mem_addr and mem_we must not change while mem_req=1 && mem_ready=0.
//     - mem_req deasserts the cycle after ready; there are no back-to-back requests.
//   mem_ready while mem_req=0 is ignored.
//   Latency (zero-wait memory): ALU op = 4 cycles, JMP/NOP/CMP = 3, LOD = 5, STR = 4.
//   Each wait state adds 1 cycle.
//   NOP (ir=0) passes through EXEC with no strobes.
// CONFIGURATION
//   SEQ_TIMEOUT_EN defined:
//     - A wait counter runs while mem_req=1 && mem_ready=0 and clears on ready.
//     - When it reaches TIMEOUT_CYCLES: go FAULT, mem_req=0, fault=1 (sticky).
//     - Only rst_n leaves FAULT.
//   SEQ_TIMEOUT_EN undefined: no counter or FAULT state; waits indefinitely; fault tied 0.
// STRUCTURE
//   Shared package cpu_pkg:
//     - seq_state_t enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
//     - opcode and FUNC_* localparams shared with the decoder.
//   Sub-module seq_watchdog: wait counter and expiry flag, instantiated only under SEQ_TIMEOUT_EN.
// TESTING
//   1. Reset: rst_n=0 mid-MEM -> same cycle mem_req=0, pc=RESET_PC, state_o=0; after release with run=1, fetch from addr 0.
//   2. ADD r3=r1+r2 (ir=0x04221800), zero-wait -> DECODE, EXEC (status_we=1), WB (reg_we=1 once); pc=1; back in FETCH on cycle 5.
//   3. JMP 0x40 (ir=0x18000040) -> pc=0x40 after EXEC, next mem_addr=0x40, no reg_we.
//   4. LOD with mem_ready delayed 3 cycles, data_addr=0x123 -> mem_req high 4 cycles, mem_addr=0x123 stable, mem_we=0, reg_we 1 cycle after ready.
//   5. STR at pc=2^26-1 -> fetch wraps pc to 0; store issues mem_we=1 and returns to FETCH without reg_we.
//   6. SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready stuck 0 -> fault=1 after 4 wait cycles, mem_req=0, held until reset; without macro, state stays FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared microcpu types: sequencer states, opcodes, ALU function codes
package cpu_pkg;

    // Encoding is visible on state_o, so values are fixed.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd5
    } seq_state_t;

    // Primary opcode lives in ir[31:26]
    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_ALU = 6'h01;
    localparam logic [5:0] OP_LOD = 6'h02;
    localparam logic [5:0] OP_STR = 6'h03;
    localparam logic [5:0] OP_CMP = 6'h05;
    localparam logic [5:0] OP_JMP = 6'h06;

    // ALU function field, ir[5:0] for OP_ALU
    localparam logic [5:0] FUNC_ADD = 6'h00;
    localparam logic [5:0] FUNC_SUB = 6'h01;
    localparam logic [5:0] FUNC_AND = 6'h02;
    localparam logic [5:0] FUNC_OR  = 6'h03;
    localparam logic [5:0] FUNC_XOR = 6'h04;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - shared memory port: req/ready handshake, address, write flag, read data
// master (sequencer): drives mem_req, mem_we, mem_addr; receives mem_ready, mem_rdata
// slave  (memory)   : the reverse
interface cpu_sequencer_if #(
    parameter int unsigned ADDR_W = 26
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - memory wait-state counter with expiry flag (present only with SEQ_TIMEOUT_EN)
// Ports: clk, rst_n (async active-low), wait_i (request outstanding, not ready),
//        expired_o (this is the TIMEOUT_CYCLES-th consecutive wait cycle)
`ifdef SEQ_TIMEOUT_EN
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Flag on the last permitted wait cycle so the sequencer can drop
    // mem_req on the very next edge: request is high exactly TIMEOUT_CYCLES.
    assign expired_o = wait_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (wait_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`endif

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB sequencer: owns PC and IR, drives the shared memory port
// Ports: clk, rst_n (async active-low); run; mem (cpu_sequencer_if.master);
//        cu_* decoded controls and data_addr in; pc, ir, reg_we, status_we, state_o, fault out.
// Option: SEQ_TIMEOUT_EN adds seq_watchdog and the sticky FAULT state; otherwise fault is tied 0.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 26,
    parameter int unsigned RESET_PC       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    cpu_sequencer_if.master     mem,
    input  logic                cu_load_pc,
    input  logic [ADDR_W-1:0]   cu_pc_val,
    input  logic                cu_mem_rd,
    input  logic                cu_mem_wr,
    input  logic                cu_reg_we,
    input  logic                cu_alu_act,
    input  logic [31:0]         data_addr,
    output logic [ADDR_W-1:0]   pc,
    output logic [31:0]         ir,
    output logic                reg_we,
    output logic                status_we,
    output logic [2:0]          state_o,
    output logic                fault
);
    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              reg_we_q, reg_we_d;
    logic              status_we_q, status_we_d;
    logic              fault_q, fault_d;
    logic              wd_expired;

    // Upper address bits are beyond the memory map.
    logic unused_data_addr_hi;
    assign unused_data_addr_hi = ^data_addr[31:ADDR_W];

`ifdef SEQ_TIMEOUT_EN
    seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .wait_i    (mem_req_q && !mem.mem_ready),
        .expired_o (wd_expired)
    );
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        reg_we_d    = 1'b0;
        status_we_d = 1'b0;
        fault_d     = fault_q;

        case (state_q)
            FETCH: begin
                if (!mem_req_q) begin
                    // run is only looked at here, before a request goes out;
                    // once issued, the fetch always completes.
                    if (run) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = pc_q;
                    end
                end else if (mem.mem_ready) begin
                    ir_d      = mem.mem_rdata;
                    pc_d      = pc_q + ADDR_W'(1);
                    mem_req_d = 1'b0;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                // Decoder outputs are already valid from the new ir, so the
                // flag strobe is registered here to land during EXEC.
                status_we_d = cu_alu_act;
                state_d     = EXEC;
            end
            EXEC: begin
                if (cu_load_pc) begin
                    pc_d    = cu_pc_val;
                    state_d = FETCH;
                end else if (cu_mem_rd || cu_mem_wr) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = cu_mem_wr && !cu_mem_rd;
                    mem_addr_d = data_addr[ADDR_W-1:0];
                    state_d    = MEM;
                end else if (cu_reg_we) begin
                    reg_we_d = 1'b1;
                    state_d  = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM: begin
                // Register file captures mem_rdata itself on this ready cycle.
                if (mem.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_we_q) begin
                        state_d = FETCH;
                    end else begin
                        reg_we_d = 1'b1;
                        state_d  = WB;
                    end
                end
            end
            WB: begin
                state_d = FETCH;
            end
`ifdef SEQ_TIMEOUT_EN
            FAULT: begin
                state_d   = FAULT;
                mem_req_d = 1'b0;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase

        // Expiry only fires while a request is stalled, so it never
        // collides with a completing transfer above.
        if (wd_expired) begin
            state_d   = FAULT;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            fault_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= ADDR_W'(RESET_PC);
            ir_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            reg_we_q    <= 1'b0;
            status_we_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            reg_we_q    <= reg_we_d;
            status_we_q <= status_we_d;
            fault_q     <= fault_d;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_addr = mem_addr_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign reg_we       = reg_we_q;
    assign status_we    = status_we_q;
    assign state_o      = state_q;
`ifdef SEQ_TIMEOUT_EN
    assign fault        = fault_q;
`else
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    localparam int unsigned ADDR_W = 26;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              cu_load_pc;
    logic [ADDR_W-1:0] cu_pc_val;
    logic              cu_mem_rd;
    logic              cu_mem_wr;
    logic              cu_reg_we;
    logic              cu_alu_act;
    logic [31:0]       data_addr;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic              reg_we;
    logic              status_we;
    logic [2:0]        state_o;
    logic              fault;

    int n_chk;
    int n_bad;

    cpu_sequencer_if #(.ADDR_W(ADDR_W)) mem_bus ();

    cpu_sequencer #(
        .ADDR_W         (ADDR_W),
        .RESET_PC       (0),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mem        (mem_bus.master),
        .cu_load_pc (cu_load_pc),
        .cu_pc_val  (cu_pc_val),
        .cu_mem_rd  (cu_mem_rd),
        .cu_mem_wr  (cu_mem_wr),
        .cu_reg_we  (cu_reg_we),
        .cu_alu_act (cu_alu_act),
        .data_addr  (data_addr),
        .pc         (pc),
        .ir         (ir),
        .reg_we     (reg_we),
        .status_we  (status_we),
        .state_o    (state_o),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cu(input logic lpc, input logic [ADDR_W-1:0] pval, input logic rd,
                          input logic wr, input logic rwe, input logic alu);
        cu_load_pc = lpc;
        cu_pc_val  = pval;
        cu_mem_rd  = rd;
        cu_mem_wr  = wr;
        cu_reg_we  = rwe;
        cu_alu_act = alu;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        data_addr = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        set_cu(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset state
        tick();
        tick();
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_ir", 64'(ir), 64'd0);
        chk("rst_req", 64'(mem_bus.mem_req), 64'd0);
        chk("rst_strobes", 64'({reg_we, status_we, fault}), 64'd0);
        chk("rst_addr", 64'(mem_bus.mem_addr), 64'd0);

        rst_n = 1'b1;
        tick();
        chk("idle_no_run", 64'(mem_bus.mem_req), 64'd0);
        run = 1'b1;
        tick();
        chk("fetch0_req", 64'(mem_bus.mem_req), 64'd1);
        chk("fetch0_addr", 64'(mem_bus.mem_addr), 64'd0);
        chk("fetch0_we", 64'(mem_bus.mem_we), 64'd0);

        // ADD r3=r1+r2, zero-wait
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0422_1800;
        set_cu(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        mem_bus.mem_ready = 1'b0;
        chk("add_decode", 64'(state_o), 64'd1);
        chk("add_ir", 64'(ir), 64'h0422_1800);
        chk("add_pc", 64'(pc), 64'd1);
        chk("add_req_drop", 64'(mem_bus.mem_req), 64'd0);
        tick();
        chk("add_exec", 64'(state_o), 64'd2);
        chk("add_status_we", 64'(status_we), 64'd1);
        chk("add_no_reg_we_exec", 64'(reg_we), 64'd0);
        tick();
        chk("add_wb", 64'(state_o), 64'd4);
        chk("add_reg_we", 64'(reg_we), 64'd1);
        chk("add_status_off", 64'(status_we), 64'd0);
        tick();
        chk("add_back_fetch", 64'(state_o), 64'd0);
        chk("add_reg_we_once", 64'(reg_we), 64'd0);
        tick();
        chk("fetch1_addr", 64'(mem_bus.mem_addr), 64'd1);

        // JMP 0x40
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h1800_0040;
        set_cu(1'b1, 26'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        mem_bus.mem_ready = 1'b0;
        chk("jmp_pc_inc", 64'(pc), 64'd2);
        tick();
        chk("jmp_no_status", 64'(status_we), 64'd0);
        tick();
        chk("jmp_fetch", 64'(state_o), 64'd0);
        chk("jmp_pc", 64'(pc), 64'h40);
        chk("jmp_no_reg_we", 64'(reg_we), 64'd0);
        tick();
        chk("jmp_next_addr", 64'(mem_bus.mem_addr), 64'h40);

        // LOD, ready delayed 3 cycles
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0801_0000;
        data_addr = 32'h0000_0123;
        set_cu(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        mem_bus.mem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lod_wait_state", 64'(state_o), 64'd3);
            chk("lod_wait_req_addr_we", 64'({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}),
                64'({1'b1, 1'b0, 26'h123}));
            chk("lod_wait_no_reg_we", 64'(reg_we), 64'd0);
            tick();
        end
        chk("lod_req_4th", 64'({mem_bus.mem_req, mem_bus.mem_addr}), 64'({1'b1, 26'h123}));
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("lod_wb", 64'(state_o), 64'd4);
        chk("lod_reg_we", 64'(reg_we), 64'd1);
        chk("lod_req_drop", 64'(mem_bus.mem_req), 64'd0);
        mem_bus.mem_ready = 1'b0;
        tick();
        chk("lod_reg_we_once", 64'(reg_we), 64'd0);

        // ready while idle is ignored; then JMP to top of address space
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h1BFF_FFFF;
        set_cu(1'b1, 26'h3FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle_ready_ignored", 64'({state_o, ir}), 64'({3'd0, 32'h0801_0000}));
        tick();
        mem_bus.mem_ready = 1'b0;
        chk("jmp2_pc_inc", 64'(pc), 64'h42);
        tick();
        tick();
        chk("jmp2_pc", 64'(pc), 64'h3FF_FFFF);
        tick();
        chk("str_fetch_addr", 64'(mem_bus.mem_addr), 64'h3FF_FFFF);

        // STR at pc=2^26-1, high address bits dropped
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0C00_0000;
        data_addr = 32'h2000_0456;
        set_cu(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        mem_bus.mem_ready = 1'b0;
        chk("str_pc_wrap", 64'(pc), 64'd0);
        tick();
        tick();
        chk("str_mem", 64'({state_o, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}),
            64'({3'd3, 1'b1, 1'b1, 26'h456}));
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        chk("str_back_fetch", 64'({state_o, mem_bus.mem_req, reg_we}), 64'({3'd0, 1'b0, 1'b0}));
        tick();
        chk("fetch_wrapped_addr", 64'(mem_bus.mem_addr), 64'd0);

        // rd and wr both set: read wins; then reset mid-MEM
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0800_0000;
        data_addr = 32'h0000_0077;
        set_cu(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        mem_bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("rdwr_read_wins", 64'({state_o, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}),
            64'({3'd3, 1'b1, 1'b0, 26'h77}));
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 64'(mem_bus.mem_req), 64'd0);
        chk("async_rst_pc_state", 64'({pc, state_o}), 64'({26'd0, 3'd0}));
        chk("async_rst_ir", 64'(ir), 64'd0);
        tick();
        rst_n = 1'b1;
        set_cu(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_rst_fetch", 64'({mem_bus.mem_req, mem_bus.mem_addr}), 64'({1'b1, 26'd0}));

        // memory never ready
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_req_held", 64'({mem_bus.mem_req, fault}), 64'({1'b1, 1'b0}));
        end
        tick();
        chk("to_fault", 64'({state_o, mem_bus.mem_req, fault}), 64'({3'd5, 1'b0, 1'b1}));
        mem_bus.mem_ready = 1'b1;
        repeat (3) tick();
        chk("to_sticky", 64'({state_o, mem_bus.mem_req, fault}), 64'({3'd5, 1'b0, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("to_rst_clears", 64'({state_o, fault}), 64'd0);
        rst_n = 1'b1;
        mem_bus.mem_ready = 1'b0;
`else
        repeat (10) tick();
        chk("stuck_stays_fetch", 64'({state_o, mem_bus.mem_req, fault}), 64'({3'd0, 1'b1, 1'b0}));
        chk("stuck_addr_stable", 64'(mem_bus.mem_addr), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
